// File: rtl/avr_xmem_mailbox_pkg.sv
// Shared constants for the AVR external-memory mailbox.
// Holds the register offsets inside the 8-byte window, the STATUS and IEN
// bit positions, the read-handshake state type and a count-to-byte helper.
package avr_xmem_mailbox_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_RXCNT  = 3'd2;
  localparam logic [2:0] REG_TXCNT  = 3'd3;
  localparam logic [2:0] REG_IEN    = 3'd4;

  localparam int unsigned ST_RXNE    = 0;
  localparam int unsigned ST_TXFULL  = 1;
  localparam int unsigned ST_TXEMPTY = 2;
  localparam int unsigned ST_RXOVF   = 3;
  localparam int unsigned ST_TXDROP  = 4;

  localparam int unsigned IEN_RXNE    = 0;
  localparam int unsigned IEN_TXEMPTY = 1;

  // Read handshake: wait state, data phase, then hold until the strobe drops.
  typedef enum logic [1:0] {
    RdIdle,
    RdData,
    RdHold
  } rd_state_e;

  // Occupancy as a register byte; only a 256-deep FIFO can exceed 8 bits.
  function automatic logic [7:0] cnt_to_byte(input logic [8:0] cnt);
    return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/mbox_sync_fifo.sv
// Synchronous byte FIFO used for both mailbox directions.
// Ports: clk/rst (sync, active-high), push/wdata write side, pop/rdata read
// side (rdata is the current head), full/empty/count status, drop pulses
// when a push is refused. A pop is evaluated before the push, so a full FIFO
// accepts a simultaneous push and pop without dropping.
module mbox_sync_fifo #(
  parameter int unsigned Depth = 16,
  localparam int unsigned CntW = $clog2(Depth) + 1,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [7:0]      wdata,
  input  logic            pop,
  output logic [7:0]      rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count,
  output logic            drop
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/avr_xmem_mailbox.sv
// AVR external data-memory responder exposing a mailbox register window.
// Ports: clk, rst (sync, active-high); AVR bus sram_a/sram_d_out/sram_cs/
// sram_oe/sram_we in, sram_d_in/sram_wait out; TX stream tx_data/tx_valid
// out with tx_ready in; RX stream rx_data/rx_valid in with rx_ready out;
// irq level interrupt out.
// Reads take one wait state (data is registered); writes take none and
// commit once per strobe.
module avr_xmem_mailbox
  import avr_xmem_mailbox_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sram_a,
  input  logic [7:0]  sram_d_out,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic [7:0]  sram_d_in,
  output logic        sram_wait,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       addr;
  logic             cs_oe;
  logic             wr_commit;
  logic             unused_addr;

  rd_state_e        rd_state_q, rd_state_d;
  logic             capture, rx_pop;
  logic [7:0]       d_in_q, rd_data;
  logic             rd_pop_q;
  logic             we_d_q;
  logic [1:0]       ien_q, ien_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic             tx_drop_q, tx_drop_d;
  logic             irq_q, irq_d;

  logic             tx_push, tx_full, tx_empty, tx_drop_evt;
  logic [CNT_W-1:0] tx_count;
  logic [7:0]       rx_head;
  logic             rx_full, rx_empty, rx_drop_evt;
  logic [CNT_W-1:0] rx_count;
  logic [7:0]       status;

  assign addr        = sram_a[2:0];
  assign unused_addr = ^sram_a[15:3];
  assign cs_oe       = sram_cs & sram_oe;
  // Edge-qualified so a multi-cycle write strobe commits only once.
  assign wr_commit   = sram_cs & sram_we & ~we_d_q;
  assign tx_push     = wr_commit & (addr == REG_DATA);

  mbox_sync_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (sram_d_out),
    .pop   (tx_ready),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .drop  (tx_drop_evt)
  );

  mbox_sync_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .drop  (rx_drop_evt)
  );

  assign tx_valid  = ~tx_empty;
  assign rx_ready  = ~rx_full;
  assign sram_d_in = d_in_q;
  assign irq       = irq_q;

  always_comb begin
    status              = '0;
    status[ST_RXNE]     = ~rx_empty;
    status[ST_TXFULL]   = tx_full;
    status[ST_TXEMPTY]  = tx_empty;
    status[ST_RXOVF]    = rx_ovf_q;
    status[ST_TXDROP]   = tx_drop_q;
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      REG_STATUS: rd_data = status;
      REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
      REG_RXCNT:  rd_data = cnt_to_byte(9'(rx_count));
      REG_TXCNT:  rd_data = cnt_to_byte(9'(tx_count));
      REG_IEN:    rd_data = {6'b0, ien_q};
      default:    rd_data = 8'h00;
    endcase
  end

  // Read handshake. Wait is suppressed while rst is high so a reset landing
  // in the wait cycle releases the core immediately.
  always_comb begin
    rd_state_d = rd_state_q;
    sram_wait  = 1'b0;
    capture    = 1'b0;
    rx_pop     = 1'b0;
    case (rd_state_q)
      RdIdle: begin
        if (cs_oe) begin
          sram_wait  = ~rst;
          capture    = 1'b1;
          rd_state_d = RdData;
        end
      end
      RdData: begin
        // Pop only if the captured byte really came from the FIFO, so a byte
        // arriving during the wait state is not lost.
        rx_pop     = cs_oe & rd_pop_q;
        rd_state_d = cs_oe ? RdHold : RdIdle;
      end
      RdHold: begin
        if (!cs_oe) rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    ien_d     = ien_q;
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    if (wr_commit && addr == REG_IEN) ien_d = sram_d_out[1:0];
    if (wr_commit && addr == REG_STATUS) begin
      if (sram_d_out[ST_RXOVF])  rx_ovf_d  = 1'b0;
      if (sram_d_out[ST_TXDROP]) tx_drop_d = 1'b0;
    end
    // New events override a same-cycle clear.
    if (rx_drop_evt) rx_ovf_d  = 1'b1;
    if (tx_drop_evt) tx_drop_d = 1'b1;
    irq_d = (ien_q[IEN_RXNE] & ~rx_empty) | (ien_q[IEN_TXEMPTY] & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RdIdle;
      d_in_q     <= 8'h00;
      rd_pop_q   <= 1'b0;
      we_d_q     <= 1'b0;
      ien_q      <= 2'b00;
      rx_ovf_q   <= 1'b0;
      tx_drop_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (capture) begin
        d_in_q   <= rd_data;
        rd_pop_q <= (addr == REG_DATA) & ~rx_empty;
      end
      we_d_q    <= sram_we;
      ien_q     <= ien_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_avr_xmem_mailbox.sv
module tb_avr_xmem_mailbox;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sram_a;
  logic [7:0]  sram_d_out;
  logic        sram_cs, sram_oe, sram_we;
  logic [7:0]  sram_d_in;
  logic        sram_wait;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  typedef struct {
    logic [2:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  avr_xmem_mailbox #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_a     (sram_a),
    .sram_d_out (sram_d_out),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .sram_d_in  (sram_d_in),
    .sram_wait  (sram_wait),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // TX scoreboard: every byte the fabric accepts must match the next queued write.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h with no byte queued", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  task automatic bus_read(input logic [2:0] addr, output logic [7:0] data);
    int cycles;
    @(posedge clk); #1;
    sram_a  = {13'h0, addr};
    sram_cs = 1'b1;
    sram_oe = 1'b1;
    cycles  = 0;
    @(negedge clk);
    while (sram_wait && cycles < 8) begin
      cycles++;
      @(negedge clk);
    end
    check("rd_wait_cycles", 32'(cycles), 32'd1);
    data = sram_d_in;
    @(posedge clk); #1;
    sram_cs = 1'b0;
    sram_oe = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(addr, d);
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic rx_read();
    logic [7:0] d, e;
    e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
    bus_read(3'd1, d);
    check("rx_data", 32'(d), 32'(e));
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    sram_a     = {13'h0, addr};
    sram_d_out = data;
    sram_cs    = 1'b1;
    sram_we    = 1'b1;
    @(posedge clk); #1;
    sram_cs = 1'b0;
    sram_we = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] data);
    if (tx_exp.size() < Depth) tx_exp.push_back(data);
    bus_write(3'd1, data);
  endtask

  task automatic rx_push(input logic [7:0] data);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = data;
    if (rx_exp.size() < Depth) rx_exp.push_back(data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_in"}, 32'(sram_d_in), 32'h00);
    check({tag, "_wait"}, 32'(sram_wait), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sram_a = '0; sram_d_out = '0; sram_cs = 0; sram_oe = 0; sram_we = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;

    // addr, write?, wdata, expected read value
    vecs[0]  = '{3'd0, 1'b0, 8'h00, 8'h04};
    vecs[1]  = '{3'd2, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{3'd3, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{3'd4, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{3'd5, 1'b1, 8'hFF, 8'h00};
    vecs[5]  = '{3'd5, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{3'd6, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{3'd7, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{3'd4, 1'b1, 8'hFE, 8'h00};
    vecs[9]  = '{3'd4, 1'b0, 8'h00, 8'h02};
    vecs[10] = '{3'd4, 1'b1, 8'h00, 8'h00};
    vecs[11] = '{3'd4, 1'b0, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // TX path: two bytes held back, then drained.
    tx_write(8'hA5);
    tx_write(8'h3C);
    read_check("txcnt_2", 3'd3, 8'h02);
    @(negedge clk);
    check("tx_valid_held", 32'(tx_valid), 32'd1);
    check("tx_head", 32'(tx_data), 32'hA5);
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check("tx_valid_drained", 32'(tx_valid), 32'd0);
    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    read_check("status_tx_empty", 3'd0, 8'h04);

    // RX overflow: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i <= Depth; i++) begin
      rx_push(8'(i));
      if (i == Depth) check("rx_ready_full", 32'(rx_ready), 32'd0);
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    read_check("rxcnt_full", 3'd2, 8'h10);
    read_check("status_rx_ovf", 3'd0, 8'h0D);
    for (int i = 0; i <= Depth; i++) rx_read();
    read_check("rxcnt_empty", 3'd2, 8'h00);
    bus_write(3'd0, 8'h08);
    read_check("status_ovf_clr", 3'd0, 8'h04);
    check("rx_ready_again", 32'(rx_ready), 32'd1);

    // TX full, drop, then simultaneous push/pop while full.
    for (int i = 0; i < Depth; i++) tx_write(8'(8'h10 + i));
    read_check("txcnt_full", 3'd3, 8'h10);
    read_check("status_tx_full", 3'd0, 8'h02);
    tx_write(8'h77);
    read_check("txcnt_after_drop", 3'd3, 8'h10);
    read_check("status_tx_drop", 3'd0, 8'h12);
    bus_write(3'd0, 8'h10);
    read_check("status_drop_clr", 3'd0, 8'h02);
    @(posedge clk); #1;
    sram_a = 16'h0001; sram_d_out = 8'h88; sram_cs = 1; sram_we = 1; tx_ready = 1;
    tx_exp.push_back(8'h88);
    @(posedge clk); #1;
    sram_cs = 0; sram_we = 0; tx_ready = 0;
    read_check("txcnt_pushpop", 3'd3, 8'h10);
    read_check("status_no_drop", 3'd0, 8'h02);
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (Depth) @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check("tx_valid_empty2", 32'(tx_valid), 32'd0);
    check("tx_queue_empty2", 32'(tx_exp.size()), 32'd0);

    // Interrupts.
    bus_write(3'd4, 8'h01);
    @(negedge clk);
    check("irq_idle", 32'(irq), 32'd0);
    rx_push(8'h5A);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rx", 32'(irq), 32'd1);
    rx_read();
    @(negedge clk);
    check("irq_after_pop", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);
    bus_write(3'd4, 8'h02);
    @(negedge clk);
    @(negedge clk);
    check("irq_tx_empty", 32'(irq), 32'd1);
    bus_write(3'd4, 8'h00);

    // Reset during the wait cycle of a DATA read.
    rx_push(8'hC3);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(posedge clk); #1;
    sram_a = 16'h0001; sram_cs = 1; sram_oe = 1;
    @(negedge clk);
    check("mid_rd_wait", 32'(sram_wait), 32'd1);
    rst = 1'b1;
    #1 check("mid_rd_wait_rst", 32'(sram_wait), 32'd0);
    rx_exp.delete();
    @(negedge clk);
    check_reset_outputs("mid_rd_rst");
    @(posedge clk); #1;
    rst = 1'b0; sram_cs = 0; sram_oe = 0;
    read_check("rxcnt_after_rst", 3'd2, 8'h00);
    read_check("status_after_rst", 3'd0, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avr_xmem_mailbox.md
Name: avr_xmem_mailbox

Overview:
- Responder on the AVR core's external data-memory bus (sram_a/sram_d_out/sram_cs/sram_oe/sram_we/sram_wait/sram_d_in).
- Exposes a small register window that the firmware reaches with ordinary LD/ST instructions.
- Behind the window sit two byte FIFOs that bridge to streaming logic on the drive side: a TX FIFO (AVR→fabric) and an RX FIFO (fabric→AVR).
- Drives the AVR's ext_irq1 line from maskable FIFO events.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of 2, range 4..256.
- CNT_W, log2(FIFO_DEPTH)+1, width of the occupancy counters; derived, do not override.

Ports:
- clk  in  1  system clock, same clock as the AVR core.
- rst  in  1  synchronous reset, active-high.
- sram_a  in  16  bus address; only [2:0] decoded, window selection is done by sram_cs.
- sram_d_out  in  8  write data from the AVR.
- sram_cs  in  1  window select.
- sram_oe  in  1  read strobe.
- sram_we  in  1  write strobe.
- sram_d_in  out  8  read data to the AVR.
- sram_wait  out  1  stall request to the AVR.
- tx_data  out  8  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  fabric accepts tx_data.
- rx_data  in  8  byte from the fabric.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  level interrupt, connected to ext_irq1.

Behaviour:
Reset:
- Both FIFOs empty; all sticky bits and IEN = 0.
- Outputs after reset: sram_d_in = 0x00, sram_wait = 0, irq = 0, tx_valid = 0, rx_ready = 1.

Register map (sram_a[2:0]):
- 0 STATUS (R/W1C).
  - bit0 rx_nempty, bit1 tx_full, bit2 tx_empty: live flags.
  - bit3 rx_ovf, bit4 tx_drop: sticky; writing 1 clears the bit.
  - bits[7:5] read 0.
- 1 DATA.
  - Read pops the RX FIFO.
  - Write pushes the TX FIFO.
- 2 RXCNT: RX occupancy, zero-extended to 8 bits, read-only.
- 3 TXCNT: TX occupancy, zero-extended to 8 bits, read-only.
- 4 IEN (R/W).
  - bit0 enables the rx_nempty interrupt, bit1 enables the tx_empty interrupt.
  - Other bits read 0.
- 5..7: read 0x00, writes ignored.

Read timing (one wait state):
- Cycle N, first cycle of sram_cs & sram_oe: sram_wait = 1, combinational from cs & oe & ~rd_phase. The registered data is captured at the end of this cycle and rd_phase is set.
- Cycle N+1: sram_wait = 0 and sram_d_in holds the captured value. The DATA pop takes effect at the end of this cycle.
- rd_phase clears when cs & oe drops. A back-to-back read therefore re-enters the wait state.
- sram_d_in holds its last value between accesses.

Write timing:
- Zero wait states.
- The write commits at the clock edge ending the cycle where cs & we are high.
- A write lasting several cycles commits once. It is edge-qualified by a registered we_d, so commit = cs & we & ~we_d.

Boundary cases:
- DATA read with RX empty: returns 0x00, no pop, no flag change.
- DATA write with TX full: byte dropped, tx_drop set.
- RX push while the RX FIFO is full: rx_ready is already 0. If the fabric asserts rx_valid anyway, the byte is dropped and rx_ov is set.
- Simultaneous push and pop on the same FIFO in one cycle: both happen and the count is unchanged. When full, a pop and push together succeed without a drop, because the pop is evaluated first.
- STATUS W1C in the same cycle as a new overflow event: the set wins.
- Pointers wrap modulo FIFO_DEPTH. Counters saturate logically at FIFO_DEPTH; overflow is handled by the drop rules above.
- irq = (IEN[0] & rx_nempty) | (IEN[1] & tx_empty), registered, so irq lags the causing event by 1 cycle.
- Reset asserted mid-read: sram_wait goes 0 in the same cycle it is sampled with reset. The reset takes effect at the next edge and wait stays 0 while rst is high. No pop occurs.

Decomposition:
- Package avr_xmem_mailbox_pkg holds:
  - the register offsets REG_STATUS..REG_IEN;
  - the STATUS bit indices ST_RXNE, ST_TXFULL, ST_TXEMPTY, ST_RXOVF, ST_TXDROP;
  - the IEN bit indices.
- One sub-module, mbox_sync_fifo: parameterized depth, 8-bit data, push/pop, full/empty/count, pop-before-push semantics. It is instantiated twice, once per direction.

Test Plan:
- Reset, then read STATUS: sram_wait high exactly 1 cycle, data = 0x04 (tx_empty only); TXCNT = 0, RXCNT = 0.
- AVR writes 0xA5, 0x3C to DATA with tx_ready = 0: TXCNT = 2, tx_valid = 1, tx_data = 0xA5. Raise tx_ready for 2 cycles: 0xA5 then 0x3C appear, tx_valid drops, STATUS bit2 = 1.
- Fabric pushes 17 bytes 0x00..0x10 with FIFO_DEPTH = 16: rx_ready = 0 after the 16th byte, RXCNT = 0x10, rx_ovf set. Sixteen DATA reads return 0x00..0x0F. A 17th read returns 0x00 with no pop. Writing 0x08 to STATUS clears rx_ovf.
- Fill TX to 16 entries, write 0x77: TXCNT stays 16, tx_drop set. In the same cycle, drive tx_ready = 1 together with another write: count unchanged, no drop.
- IEN = 0x01, fabric pushes 1 byte: irq rises 1 cycle later; DATA read pops it and irq falls the cycle after the pop. IEN = 0x02 with TX empty: irq = 1.
- Assert rst during the wait cycle of a DATA read: no pop (RXCNT is 0 after reset anyway), sram_wait = 0, all outputs at their reset values next cycle.
